// File: rtl/rv32i_fetch_pkg.sv
// Shared types and constants for the rv32i instruction fetch stage.
package rv32i_fetch_pkg;

  localparam int          FETCH_PC_W = 8;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  typedef struct packed {
    logic [FETCH_PC_W-1:0] pc;
    logic [31:0]           instr;
  } fetch_entry_t;

  // Saturating increment used by the optional performance counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != '1)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of fetch entries; flush overrides push and pop.
module fetch_fifo
  import rv32i_fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  entry_t                   push_data_i,
  input  logic                     pop_i,
  output entry_t                   head_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign do_push = push_i && !flush_i;
  assign do_pop  = pop_i && !flush_i && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; the empty flag masks stale contents.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/rv32i_fetch_unit.sv
// rv32i fetch stage: PC, credit-limited imem requests, prefetch FIFO, redirect flush.
// Optional FETCH_PERF_EN adds saturating perf_fetched/perf_dropped/perf_stall counters.
module rv32i_fetch_unit
  import rv32i_fetch_pkg::*;
#(
  parameter int                  PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter int                  DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_gnt,
  input  logic                imem_rvalid,
  input  logic [31:0]         imem_rdata,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [31:0]         instruction,
  output logic [PC_WIDTH-1:0] instr_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]         perf_fetched,
  output logic [31:0]         perf_dropped,
  output logic [31:0]         perf_stall
`endif
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_L = (CW + 1)'(DEPTH);

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [31:0]         instr;
  } entry_t;

  logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [PC_WIDTH-1:0] last_pc_q, last_pc_d;
  logic [CW-1:0]       outstanding_q, outstanding_d;
  logic [CW-1:0]       drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]       fifo_count;
  logic [PC_WIDTH-1:0] redirect_base;
  logic                fifo_empty, grant, dropping, push, pop;
  entry_t              head, push_entry;

  // Handshakes: a request transfers on imem_req & imem_gnt; an instruction
  // transfers on instr_valid & instr_ready. imem_addr holds while waiting for gnt.
  assign redirect_base = {redirect_pc[PC_WIDTH-1:2], 2'b00};
  assign imem_req  = !rst && !redirect_valid &&
                     (({1'b0, outstanding_q} + {1'b0, fifo_count}) < DEPTH_L);
  assign imem_addr = fetch_pc_q;
  assign grant     = imem_req && imem_gnt;

  // Responses to requests issued before a redirect are discarded in order.
  assign dropping   = imem_rvalid && (redirect_valid || (drop_cnt_q != '0));
  assign push       = imem_rvalid && !dropping;
  assign pop        = instr_valid && instr_ready && !redirect_valid;
  assign push_entry = '{pc: resp_pc_q, instr: imem_rdata};

  always_comb begin
    outstanding_d = outstanding_q + CW'(grant) - CW'(imem_rvalid);
    fetch_pc_d    = grant ? fetch_pc_q + PC_WIDTH'(4) : fetch_pc_q;
    resp_pc_d     = push ? resp_pc_q + PC_WIDTH'(4) : resp_pc_q;
    last_pc_d     = push ? resp_pc_q : last_pc_q;
    drop_cnt_d    = (imem_rvalid && (drop_cnt_q != '0)) ? drop_cnt_q - CW'(1) : drop_cnt_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_base;
      resp_pc_d  = redirect_base;
      last_pc_d  = RESET_PC;
      drop_cnt_d = outstanding_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      last_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      last_pc_q     <= last_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && imem_rvalid) begin
      assert (outstanding_q != '0);
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (redirect_valid),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign instr_valid = !fifo_empty;
  assign instruction = fifo_empty ? NOP_INSTR : head.instr;
  assign instr_pc    = fifo_empty ? last_pc_q : head.pc;

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_dropped_q, perf_stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_dropped_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_fetched_q <= sat_inc(perf_fetched_q, push);
      perf_dropped_q <= sat_inc(perf_dropped_q, dropping);
      perf_stall_q   <= sat_inc(perf_stall_q, instr_ready && !instr_valid);
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_dropped = perf_dropped_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Testbench for rv32i_fetch_unit: random-latency memory model, sequential-stream scoreboard.
module tb_rv32i_fetch_unit;

  localparam int          PCW      = 8;
  localparam logic [7:0]  RST_PC   = 8'h00;
  localparam int          DEPTH    = 4;
  localparam int          W        = PCW + 32;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           imem_req;
  logic [PCW-1:0] imem_addr;
  logic           imem_gnt = 1'b0;
  logic           imem_rvalid = 1'b0;
  logic [31:0]    imem_rdata = '0;
  logic           redirect_valid = 1'b0;
  logic [PCW-1:0] redirect_pc = '0;
  logic           instr_valid;
  logic           instr_ready = 1'b0;
  logic [31:0]    instruction;
  logic [PCW-1:0] instr_pc;
`ifdef FETCH_PERF_EN
  logic [31:0]    perf_fetched, perf_dropped, perf_stall;
`endif

  rv32i_fetch_unit #(
    .PC_WIDTH (PCW),
    .RESET_PC (RST_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instruction    (instruction),
    .instr_pc       (instr_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_dropped   (perf_dropped),
    .perf_stall     (perf_stall)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- counters and scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int pops    = 0;
  int grant_cnt = 0;
  int gnt_mode = 1;   // 0: never grant, 1: always, 2: random
  int lat_min  = 1;
  int lat_max  = 1;

  logic [W-1:0]   exp_q[$];
  logic [PCW-1:0] exp_next;

  function automatic logic [31:0] word_at(input logic [7:0] a);
    return {~a, a ^ 8'h5A, 8'hC3, a};
  endfunction

  // The instruction stream is simply consecutive words from the last restart point.
  function automatic void top_up();
    while (exp_q.size() < 8) begin
      exp_q.push_back({exp_next, word_at(exp_next)});
      exp_next = exp_next + 8'd4;
    end
  endfunction

  function automatic void restart(input logic [PCW-1:0] pc);
    exp_q.delete();
    exp_next = {pc[PCW-1:2], 2'b00};
    top_up();
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- instruction memory model ----------------
  logic [7:0] pend_addr[$];
  int         pend_due[$];
  logic       mem_fire;
  logic [7:0] mem_faddr;
  int         mem_cyc = 0;

  initial begin
    forever begin
      @(negedge clk);
      mem_fire  = imem_req && imem_gnt && !rst;
      mem_faddr = imem_addr;
      @(posedge clk);
      #2;
      mem_cyc++;
      if (rst) begin
        pend_addr.delete();
        pend_due.delete();
      end else if (mem_fire) begin
        pend_addr.push_back(mem_faddr);
        pend_due.push_back(mem_cyc - 1 + int'($urandom_range(lat_min, lat_max)));
      end
      if (!rst && pend_addr.size() > 0 && pend_due[0] <= mem_cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = word_at(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
      end
      imem_gnt = (gnt_mode == 1) || ((gnt_mode == 2) && ($urandom_range(0, 99) < 70));
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (imem_req && imem_gnt) grant_cnt++;
      if (instr_valid && instr_ready && !redirect_valid) begin
        top_up();
        check("instr_stream", 64'({instr_pc, instruction}), 64'(exp_q.pop_front()));
        pops++;
      end else if (!instr_valid) begin
        check("idle_nop", 64'(instruction), 64'(NOP));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset(input int gm, input int lmin, input int lmax, input logic rdy);
    step();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    instr_ready    = rdy;
    gnt_mode       = gm;
    lat_min        = lmin;
    lat_max        = lmax;
    restart(RST_PC);
    repeat (3) step();
    rst = 1'b0;
  endtask

  task automatic redirect_to(input logic [PCW-1:0] pc);
    step();
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    restart(pc);
    step();
    redirect_valid = 1'b0;
  endtask

  logic got;
  int   pops_start;

  initial begin
    restart(RST_PC);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req",    64'(imem_req), 64'(0));
    check("rst_valid",  64'(instr_valid), 64'(0));
    check("rst_instr",  64'(instruction), 64'(NOP));
    check("rst_pc",     64'(instr_pc), 64'(RST_PC));
`ifdef FETCH_PERF_EN
    check("rst_perf", 64'({perf_fetched, perf_dropped} | 64'(perf_stall)), 64'(0));
`endif

    // Streaming at full rate from reset.
    do_reset(1, 1, 1, 1'b1);
    @(negedge clk);
    check("t1_req0",   64'(imem_req), 64'(1));
    check("t1_addr0",  64'(imem_addr), 64'(8'h00));
    check("t1_valid0", 64'(instr_valid), 64'(0));
    @(negedge clk);
    check("t1_valid1", 64'(instr_valid), 64'(0));
    @(negedge clk);
    check("t1_valid2", 64'(instr_valid), 64'(1));
    check("t1_pc2",    64'(instr_pc), 64'(8'h00));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("t1_throughput", 64'(instr_valid), 64'(1));
    end

    // Back-pressure: credits cap issued requests at DEPTH.
    do_reset(1, 1, 1, 1'b0);
    grant_cnt = 0;
    repeat (10) step();
    @(negedge clk);
    check("t2_grants", 64'(grant_cnt), 64'(4));
    check("t2_req_off", 64'(imem_req), 64'(0));
    step();
    instr_ready = 1'b1;
    repeat (12) step();

    // Late responses after a redirect are dropped.
    do_reset(1, 2, 2, 1'b1);
    repeat (8) step();
    redirect_to(8'h40);
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      if (instr_valid) begin
        got = 1'b1;
        check("t3_pc",    64'(instr_pc), 64'(8'h40));
        check("t3_instr", 64'(instruction), 64'(word_at(8'h40)));
      end
    end
    if (!got) begin
      n_tests++;
      n_fail++;
      $display("FAIL t3_timeout: got no instr_valid, expected one within 12 cycles");
    end
`ifdef FETCH_PERF_EN
    check("t3_perf_dropped", 64'(perf_dropped), 64'(2));
`endif
    repeat (6) step();

    // Address held while grant is withheld.
    do_reset(0, 1, 1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_req_hold",  64'(imem_req), 64'(1));
      check("t4_addr_hold", 64'(imem_addr), 64'(8'h00));
    end
    step();
    gnt_mode = 1;
    @(negedge clk);
    check("t4_addr_gnt", 64'(imem_addr), 64'(8'h00));
    @(negedge clk);
    check("t4_addr_next", 64'(imem_addr), 64'(8'h04));
    repeat (4) step();

    // Misaligned redirect near the top of the address space wraps.
    redirect_to(8'hFE);
    @(negedge clk);
    check("t5_addr_fc", 64'(imem_addr), 64'(8'hFC));
    @(negedge clk);
    check("t5_addr_wrap", 64'(imem_addr), 64'(8'h00));
    repeat (10) step();

    // Redirect colliding with a response and a pop while two entries are buffered.
    do_reset(1, 1, 1, 1'b0);
    repeat (3) step();
    redirect_valid = 1'b1;
    redirect_pc    = 8'h80;
    instr_ready    = 1'b1;
    restart(8'h80);
    @(negedge clk);
    check("t6_pre_valid", 64'(instr_valid), 64'(1));
    check("t6_pre_pc",    64'(instr_pc), 64'(8'h00));
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("t6_flushed_valid", 64'(instr_valid), 64'(0));
    check("t6_flushed_instr", 64'(instruction), 64'(NOP));
    repeat (10) step();

    // Randomized traffic: grants, latency, ready, redirects and one mid-run reset.
    gnt_mode   = 2;
    lat_min    = 1;
    lat_max    = 3;
    pops_start = pops;
    for (int i = 0; i < 3000; i++) begin
      step();
      instr_ready    = ($urandom_range(0, 3) != 0);
      redirect_valid = 1'b0;
      if (i == 1500) begin
        rst = 1'b1;
        restart(RST_PC);
      end else if (i == 1503) begin
        rst = 1'b0;
      end
      if (!rst && ($urandom_range(0, 24) == 0)) begin
        redirect_valid = 1'b1;
        redirect_pc    = 8'($urandom_range(0, 255));
        restart(redirect_pc);
      end
    end
    step();
    redirect_valid = 1'b0;
    repeat (5) step();
    check("random_progress", 64'(pops - pops_start > 500), 64'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
